// File: rtl/req_arbiter_16_pkg.sv
// Shared definitions for the 16-requester arbiter: widths, FSM states and
// the rotation helper used to turn fixed priority into round-robin.
package req_arbiter_16_pkg;

    localparam int N_REQ = 16;
    localparam int ID_W  = 4;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } arb_state_e;

    // Rotate left with wrap; bit j moves to (j + sh) mod 16.
    function automatic logic [N_REQ-1:0] rotl16(input logic [N_REQ-1:0] v,
                                                input logic [ID_W-1:0]  sh);
        logic [2*N_REQ-1:0] tmp;
        tmp = {v, v} << sh;
        return tmp[2*N_REQ-1:N_REQ];
    endfunction

endpackage

// File: rtl/req_arbiter_16_if.sv
// Request/grant bundle between request sources (master) and the arbiter (slave).
interface req_arbiter_16_if;
    import req_arbiter_16_pkg::*;

    logic [N_REQ-1:0] req;
    logic             mode;
    logic [N_REQ-1:0] grant;
    logic [ID_W-1:0]  grant_id;
    logic             grant_vld;

    modport master (
        output req,
        output mode,
        input  grant,
        input  grant_id,
        input  grant_vld
    );

    modport slave (
        input  req,
        input  mode,
        output grant,
        output grant_id,
        output grant_vld
    );

endinterface

// File: rtl/req_arbiter_16_prio_pick.sv
// Combinational 16-to-4 priority picker: highest set index wins, any_o flags
// a non-empty input. Index is 0 when nothing is set.
module prio_pick_16
    import req_arbiter_16_pkg::*;
(
    input  logic [N_REQ-1:0] vec_i,
    output logic [ID_W-1:0]  idx_o,
    output logic             any_o
);

    // Ascending scan so the last (highest) set bit overrides lower ones.
    always_comb begin
        idx_o = 4'd0;
        any_o = |vec_i;
        for (int i = 0; i < N_REQ; i++) begin
            if (vec_i[i]) begin
                idx_o = 4'(i);
            end else begin
                idx_o = idx_o;
            end
        end
    end

endmodule

// File: rtl/req_arbiter_16.sv
// 16-requester arbiter: fixed or round-robin priority, grant held until
// release, optional hold-timeout preemption when others are waiting.
module req_arbiter_16
    import req_arbiter_16_pkg::*;
#(
    parameter int MAX_HOLD = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    req_arbiter_16_if.slave   bus
);

    localparam int HC_W   = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
    localparam int HC_MAX = (MAX_HOLD > 0) ? (MAX_HOLD - 1) : 0;

    arb_state_e       state_q,    state_d;
    logic [N_REQ-1:0] grant_q,    grant_d;
    logic [ID_W-1:0]  grant_id_q, grant_id_d;
    logic             grant_vld_q, grant_vld_d;
    logic [HC_W-1:0]  hold_cnt_q, hold_cnt_d;
    logic [ID_W-1:0]  last_id_q,  last_id_d;

    logic [N_REQ-1:0] others_s;
    logic [N_REQ-1:0] cand_s;
    logic [N_REQ-1:0] cand_rot_s;
    logic [ID_W-1:0]  rot_sh_s;
    logic [ID_W-1:0]  pick_rot_id_s;
    logic             pick_any_s;
    logic [ID_W-1:0]  win_id_s;
    logic             timeout_s;
    logic             new_grant_s;

    // Candidate vector and rotation so that last_id-1 lands on bit 15.
    always_comb begin
        others_s = bus.req & ~grant_q;
        if (state_q == ST_IDLE) begin
            cand_s = bus.req;
        end else begin
            cand_s = others_s;
        end
        if (bus.mode) begin
            rot_sh_s = 4'd0 - last_id_q;
        end else begin
            rot_sh_s = 4'd0;
        end
        cand_rot_s = rotl16(cand_s, rot_sh_s);
        win_id_s   = pick_rot_id_s - rot_sh_s;
        timeout_s  = (MAX_HOLD != 0) && (hold_cnt_q == HC_W'(HC_MAX));
    end

    prio_pick_16 u_pick (
        .vec_i (cand_rot_s),
        .idx_o (pick_rot_id_s),
        .any_o (pick_any_s)
    );

    // Next-state: arbitration points load a new winner, otherwise hold.
    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        grant_id_d  = grant_id_q;
        grant_vld_d = grant_vld_q;
        hold_cnt_d  = hold_cnt_q;
        last_id_d   = last_id_q;
        new_grant_s = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (pick_any_s) begin
                    new_grant_s = 1'b1;
                end else begin
                    new_grant_s = 1'b0;
                end
            end
            ST_GRANT: begin
                if (!bus.req[grant_id_q]) begin
                    if (pick_any_s) begin
                        new_grant_s = 1'b1;
                    end else begin
                        state_d     = ST_IDLE;
                        grant_d     = 16'h0000;
                        grant_id_d  = 4'd0;
                        grant_vld_d = 1'b0;
                        hold_cnt_d  = HC_W'(0);
                    end
                end else if (timeout_s && pick_any_s) begin
                    new_grant_s = 1'b1;
                end else if (hold_cnt_q != HC_W'(HC_MAX)) begin
                    hold_cnt_d = hold_cnt_q + HC_W'(1);
                end else begin
                    hold_cnt_d = hold_cnt_q;
                end
            end
            default: begin
                state_d     = ST_IDLE;
                grant_d     = 16'h0000;
                grant_id_d  = 4'd0;
                grant_vld_d = 1'b0;
                hold_cnt_d  = HC_W'(0);
            end
        endcase

        if (new_grant_s) begin
            state_d     = ST_GRANT;
            grant_d     = 16'd1 << win_id_s;
            grant_id_d  = win_id_s;
            grant_vld_d = 1'b1;
            hold_cnt_d  = HC_W'(0);
            last_id_d   = win_id_s;
        end else begin
            last_id_d   = last_id_q;
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            grant_q     <= 16'h0000;
            grant_id_q  <= 4'd0;
            grant_vld_q <= 1'b0;
            hold_cnt_q  <= HC_W'(0);
            last_id_q   <= 4'd0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            grant_id_q  <= grant_id_d;
            grant_vld_q <= grant_vld_d;
            hold_cnt_q  <= hold_cnt_d;
            last_id_q   <= last_id_d;
        end
    end

    assign bus.grant     = grant_q;
    assign bus.grant_id  = grant_id_q;
    assign bus.grant_vld = grant_vld_q;

endmodule

// File: tb/tb_req_arbiter_16.sv
// Directed self-checking bench for req_arbiter_16 (MAX_HOLD = 8).
module tb_req_arbiter_16;
    import req_arbiter_16_pkg::*;

    logic clk;
    logic rst_n;
    int   n_tests;
    int   n_fail;
    logic [3:0] exp_id;

    req_arbiter_16_if bus ();

    req_arbiter_16 #(.MAX_HOLD(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_tests++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic check_grant(input string tag, input logic [3:0] id);
        check({tag, "_id"},  32'(bus.grant_id), 32'(id));
        check({tag, "_oh"},  32'(bus.grant), 32'(16'd1 << id));
        check({tag, "_vld"}, 32'(bus.grant_vld), 32'd1);
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_grant"}, 32'(bus.grant), 32'd0);
        check({tag, "_id"},    32'(bus.grant_id), 32'd0);
        check({tag, "_vld"},   32'(bus.grant_vld), 32'd0);
    endtask

    initial begin
        n_tests  = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        bus.req  = 16'h0000;
        bus.mode = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        check_idle("reset_idle");

        // Basic grant: highest of bits 5 and 2 in fixed mode.
        bus.req = 16'h0024;
        tick();
        check_grant("basic_5", 4'd5);
        bus.req = 16'h0000;
        tick();
        check_idle("basic_release");

        // Fixed-priority handover with no bubble.
        bus.req = 16'h8001;
        tick();
        check_grant("fix_15", 4'd15);
        bus.req = 16'h0001;
        tick();
        check_grant("fix_handover_0", 4'd0);
        bus.req = 16'h0000;
        tick();
        check_idle("fix_to_idle");

        // Round-robin: each holder releases after one cycle and re-raises.
        bus.mode = 1'b1;
        bus.req  = 16'hFFFF;
        tick();
        exp_id = 4'd15;
        check_grant("rr_first", exp_id);
        for (int i = 0; i < 16; i++) begin
            bus.req = 16'hFFFF & ~(16'd1 << exp_id);
            tick();
            exp_id = exp_id - 4'd1;
            check_grant("rr_step", exp_id);
        end
        bus.req = 16'h0000;
        tick();
        check_idle("rr_idle");

        // Timeout preemption between 9 and 3, 8 cycles each.
        bus.req = 16'h0208;
        for (int seg = 0; seg < 3; seg++) begin
            for (int c = 0; c < 8; c++) begin
                tick();
                check("to_hold_id", 32'(bus.grant_id), (seg == 1) ? 32'd3 : 32'd9);
            end
        end
        tick();
        check("to_preempt_again", 32'(bus.grant_id), 32'd3);
        // Only 9 requesting: it is granted and then holds indefinitely.
        bus.req = 16'h0200;
        for (int c = 0; c < 20; c++) begin
            tick();
            check("solo_hold_id", 32'(bus.grant_id), 32'd9);
        end
        bus.req = 16'h0000;
        tick();
        check_idle("solo_idle");

        // Mode change mid-grant takes effect only at the release decision.
        bus.mode = 1'b0;
        bus.req  = 16'h0210;
        tick();
        check_grant("mc_fix_9", 4'd9);
        bus.mode = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            check_grant("mc_hold_9", 4'd9);
        end
        // Release 9 while 15 arrives: round-robin from last_id=9 picks 4.
        bus.req = 16'h8010;
        tick();
        check_grant("mc_rr_4", 4'd4);

        // Asynchronous reset mid-grant.
        #1;
        rst_n = 1'b0;
        #1;
        check_idle("async_rst");
        bus.req = 16'h0100;
        tick();
        check_idle("rst_held");
        rst_n = 1'b1;
        tick();
        check_grant("post_rst_8", 4'd8);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
